bitop_accelerator: RTL and testbench

//  Parametrised memory-mapped bit-operation accelerator; successor to the single-register bit-op slave.

---
 rtl/bitop_accel_pkg.sv | 31 +++
 rtl/bitop_serial_unit.sv | 76 +++++++
 rtl/bitop_accelerator.sv | 195 +++++++++++++++++++
 tb/tb_bitop_accelerator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitop_accel_pkg.sv
// Shared constants for the bit-operation accelerator: opcodes, register map,
// STATUS bit positions and CTRL field layout.
package bitop_accel_pkg;

  localparam logic [2:0] OP_REV    = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_INV    = 3'd2;
  localparam logic [2:0] OP_POPCNT = 3'd3;
  localparam logic [2:0] OP_CLZ    = 3'd4;

  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_STATUS  = 1;
  localparam int unsigned REG_RESULT  = 2;
  localparam int unsigned REG_IRQ_EN  = 3;
  localparam int unsigned REG_CH_BASE = 4;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_ERR   = 2;
  localparam int unsigned ST_CARRY = 3;

  localparam int unsigned CTRL_OP_LSB  = 0;
  localparam int unsigned CTRL_SRC_LSB = 4;
  localparam int unsigned CTRL_WB_BIT  = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bitop_serial_unit.sv
// Bit-serial POPCNT/CLZ engine: consumes one operand bit per cycle, MSB first,
// and flags done on the cycle its last bit is consumed (fixed DATA_W latency).
module bitop_serial_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_clz,
  input  logic [DATA_W-1:0] operand,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              seen_q, seen_d;
  logic              clz_q, clz_d;
  logic              active_q, active_d;
  logic              bit_cur;

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    seen_d   = seen_q;
    clz_d    = clz_q;
    active_d = active_q;
    done     = 1'b0;
    bit_cur  = shift_q[DATA_W-1];
    if (start) begin
      shift_d  = operand;
      cnt_d    = CNT_W'(DATA_W);
      acc_d    = '0;
      seen_d   = 1'b0;
      clz_d    = is_clz;
      active_d = 1'b1;
    end else if (active_q) begin
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q - CNT_W'(1);
      // CLZ freezes its count once the first one has gone past
      if (clz_q) begin
        if (!seen_q && !bit_cur) acc_d = acc_q + CNT_W'(1);
        if (bit_cur) seen_d = 1'b1;
      end else if (bit_cur) begin
        acc_d = acc_q + CNT_W'(1);
      end
      if (cnt_q == CNT_W'(1)) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end
    result = {{(DATA_W-CNT_W){1'b0}}, acc_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      seen_q   <= 1'b0;
      clz_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      seen_q   <= seen_d;
      clz_q    <= clz_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/bitop_accelerator.sv
// Memory-mapped bit-operation accelerator: channel register file, command FSM,
// single-cycle REV/INC/INV datapath, serial POPCNT/CLZ unit, status and irq.
//   state  | meaning
//   S_IDLE | waiting for a valid CTRL write
//   S_RUN  | op in flight on the snapshotted operand; busy=1
module bitop_accelerator
  import bitop_accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        src_q, src_d;
  logic              wb_q, wb_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              carry_q, carry_d;
  logic              irq_en_q, irq_en_d;
  logic [DATA_W-1:0] ch_q [NUM_CH];
  logic [DATA_W-1:0] ch_d [NUM_CH];

  logic [2:0]        cmd_op, cmd_src;
  logic              cmd_wb, cmd_bad;
  logic [DATA_W-1:0] sel_operand;
  logic              start_serial;
  logic              serial_done;
  logic [DATA_W-1:0] serial_result;
  logic [DATA_W-1:0] rev_val, inc_val;
  logic              inc_co;
  logic              fin;
  logic [DATA_W-1:0] fin_val;

  always_comb begin
    cmd_op      = writedata[CTRL_OP_LSB +: 3];
    cmd_src     = writedata[CTRL_SRC_LSB +: 3];
    cmd_wb      = writedata[CTRL_WB_BIT];
    cmd_bad     = (cmd_op > OP_CLZ) || (int'(cmd_src) >= NUM_CH);
    sel_operand = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (cmd_src == 3'(n)) sel_operand = ch_q[n];
    end
  end

  always_comb begin
    rev_val = '0;
    for (int i = 0; i < DATA_W; i++) rev_val[i] = operand_q[DATA_W-1-i];
    {inc_co, inc_val} = {1'b0, operand_q} + (DATA_W+1)'(1);
  end

  bitop_serial_unit #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_serial (
    .clk     (clk),
    .reset   (reset),
    .start   (start_serial),
    .is_clz  (cmd_op == OP_CLZ),
    .operand (sel_operand),
    .done    (serial_done),
    .result  (serial_result)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    operand_d    = operand_q;
    op_d         = op_q;
    src_d        = src_q;
    wb_d         = wb_q;
    done_d       = done_q;
    err_d        = err_q;
    carry_d      = carry_q;
    irq_en_d     = irq_en_q;
    ch_d         = ch_q;
    start_serial = 1'b0;
    fin          = 1'b0;
    fin_val      = '0;

    if (wr_en) begin
      if (addr == ADDR_W'(REG_STATUS)) begin
        if (writedata[ST_DONE])  done_d  = 1'b0;
        if (writedata[ST_ERR])   err_d   = 1'b0;
        if (writedata[ST_CARRY]) carry_d = 1'b0;
      end
      if (addr == ADDR_W'(REG_IRQ_EN)) irq_en_d = writedata[0];
      for (int n = 0; n < NUM_CH; n++) begin
        if (addr == ADDR_W'(REG_CH_BASE + n)) ch_d[n] = writedata;
      end
      if (addr == ADDR_W'(REG_CTRL)) begin
        if (state_q == S_RUN || cmd_bad) begin
          err_d = 1'b1;
        end else begin
          ctrl_d       = writedata;
          op_d         = cmd_op;
          src_d        = cmd_src;
          wb_d         = cmd_wb;
          operand_d    = sel_operand;
          state_d      = S_RUN;
          start_serial = (cmd_op == OP_POPCNT) || (cmd_op == OP_CLZ);
        end
      end
    end

    // Completion is applied after bus writes so it overrides W1C and CH writes
    if (state_q == S_RUN) begin
      case (op_q)
        OP_REV:            begin fin = 1'b1; fin_val = rev_val;    end
        OP_INC:            begin fin = 1'b1; fin_val = inc_val;    end
        OP_INV:            begin fin = 1'b1; fin_val = ~operand_q; end
        OP_POPCNT, OP_CLZ: begin fin = serial_done; fin_val = serial_result; end
        default:           fin = 1'b1;
      endcase
      if (fin) begin
        result_d = fin_val;
        done_d   = 1'b1;
        state_d  = S_IDLE;
        if (op_q == OP_INC) carry_d = inc_co;
        if (wb_q) begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (src_q == 3'(n)) ch_d[n] = fin_val;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      result_q  <= '0;
      operand_q <= '0;
      op_q      <= '0;
      src_q     <= '0;
      wb_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      carry_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) ch_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      src_q     <= src_d;
      wb_q      <= wb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      carry_q   <= carry_d;
      irq_en_q  <= irq_en_d;
      ch_q      <= ch_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (rd_en) begin
      if (addr == ADDR_W'(REG_CTRL)) readdata = ctrl_q;
      if (addr == ADDR_W'(REG_STATUS)) begin
        readdata[ST_BUSY]  = (state_q == S_RUN);
        readdata[ST_DONE]  = done_q;
        readdata[ST_ERR]   = err_q;
        readdata[ST_CARRY] = carry_q;
      end
      if (addr == ADDR_W'(REG_RESULT)) readdata = result_q;
      if (addr == ADDR_W'(REG_IRQ_EN)) readdata[0] = irq_en_q;
      for (int n = 0; n < NUM_CH; n++) begin
        if (addr == ADDR_W'(REG_CH_BASE + n)) readdata = ch_q[n];
      end
    end
  end

  assign irq = done_q & irq_en_q;

endmodule

// File: tb/tb_bitop_accelerator.sv
// Directed and randomized checks of bitop_accelerator against a behavioural model.
module tb_bitop_accelerator;

  localparam int DW = 32;
  localparam int NCH = 4;
  localparam int AW = 4;

  localparam logic [AW-1:0] A_CTRL   = 4'd0;
  localparam logic [AW-1:0] A_STATUS = 4'd1;
  localparam logic [AW-1:0] A_RESULT = 4'd2;
  localparam logic [AW-1:0] A_IRQ_EN = 4'd3;
  localparam logic [AW-1:0] A_CH0    = 4'd4;

  logic          clk = 1'b0;
  logic          reset, rd_en, wr_en, irq;
  logic [AW-1:0] addr;
  logic [DW-1:0] writedata, readdata;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [DW-1:0] m_ch [NCH];
  logic [DW-1:0] m_result, m_ctrl;
  logic          m_done, m_err, m_carry, m_irq_en;

  logic [2:0]    p_op, p_src;
  logic          p_wb;
  logic [DW-1:0] p_x;
  int            p_t0;

  bitop_accelerator #(.DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sits in the low clock phase; the write lands on the next posedge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; writedata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
    addr = a; rd_en = 1'b1;
    #1;
    d = readdata;
    rd_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_op(input logic [2:0] op, input logic [DW-1:0] x);
    logic [DW-1:0] r;
    logic found;
    r = '0;
    case (op)
      3'd0: for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
      3'd1: r = x + 1;
      3'd2: r = ~x;
      3'd3: r = 32'($countones(x));
      default: begin
        found = 1'b0;
        r = 32'(DW);
        for (int i = DW-1; i >= 0; i--) begin
          if (!found && x[i]) begin
            r = 32'(DW-1-i);
            found = 1'b1;
          end
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_status();
    return {28'b0, m_carry, m_err, m_done, 1'b0};
  endfunction

  function automatic logic [DW-1:0] ctrl_word(input logic [2:0] op, input logic [2:0] src, input logic wb);
    return {23'b0, wb, 1'b0, src, 1'b0, op};
  endfunction

  task automatic bus_ch(input int n, input logic [DW-1:0] d);
    wr(A_CH0 + AW'(n), d);
    m_ch[n] = d;
  endtask

  task automatic w1c(input logic [DW-1:0] d);
    wr(A_STATUS, d);
    if (d[1]) m_done = 1'b0;
    if (d[2]) m_err = 1'b0;
    if (d[3]) m_carry = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [2:0] src, input logic wb);
    logic [DW-1:0] st;
    p_op = op; p_src = src; p_wb = wb; p_x = m_ch[src];
    wr(A_CTRL, ctrl_word(op, src, wb));
    p_t0 = cyc_cnt;
    m_ctrl = ctrl_word(op, src, wb);
    peek(A_STATUS, st);
    check("busy_after_start", {31'b0, st[0]}, 32'd1);
  endtask

  task automatic finish_op();
    logic [DW-1:0] st, d, exp;
    int guard;
    guard = 0;
    peek(A_STATUS, st);
    while (st[0] && guard < 200) begin
      @(negedge clk);
      guard++;
      peek(A_STATUS, st);
    end
    check("latency", 32'(cyc_cnt - p_t0), (p_op >= 3'd3) ? 32'(DW) : 32'd1);
    exp = model_op(p_op, p_x);
    m_result = exp;
    m_done = 1'b1;
    if (p_op == 3'd1) m_carry = (p_x == '1);
    if (p_wb) m_ch[p_src] = exp;
    peek(A_RESULT, d);
    check("result", d, exp);
    peek(A_STATUS, d);
    check("status_done", d, exp_status());
    peek(A_CH0 + AW'(p_src), d);
    check("ch_after_op", d, m_ch[p_src]);
    check("irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) m_ch[n] = '0;
    m_result = '0; m_ctrl = '0;
    m_done = 1'b0; m_err = 1'b0; m_carry = 1'b0; m_irq_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d, v;
    logic [2:0] op, src;
    logic wb, ie;
    int sel;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      peek(AW'(a), d);
      check("reset_read", d, '0);
      @(negedge clk);
    end
    check("reset_irq", {31'b0, irq}, '0);

    // REV of 1
    bus_ch(1, 32'h0000_0001);
    start_op(3'd0, 3'd1, 1'b0);
    finish_op();

    // INC overflow with writeback, then W1C everything
    bus_ch(0, 32'hFFFF_FFFF);
    start_op(3'd1, 3'd0, 1'b1);
    finish_op();
    w1c(32'hE);
    peek(A_STATUS, d);
    check("status_cleared", d, 32'h0);

    // POPCNT and level irq
    bus_ch(2, 32'hF0F0_0001);
    start_op(3'd3, 3'd2, 1'b0);
    finish_op();
    wr(A_IRQ_EN, 32'h1); m_irq_en = 1'b1;
    check("irq_level", {31'b0, irq}, 32'd1);
    w1c(32'h2);
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // CLZ, including all-zero operand, and CTRL write while busy
    bus_ch(3, 32'h0000_8000);
    start_op(3'd4, 3'd3, 1'b0);
    finish_op();
    bus_ch(3, 32'h0);
    start_op(3'd4, 3'd3, 1'b0);
    wr(A_CTRL, ctrl_word(3'd0, 3'd1, 1'b0));
    m_err = 1'b1;
    finish_op();
    peek(A_CTRL, d);
    check("ctrl_kept", d, m_ctrl);
    w1c(32'hE);

    // Illegal op and out-of-range source
    wr(A_CTRL, ctrl_word(3'd6, 3'd0, 1'b0)); m_err = 1'b1;
    peek(A_STATUS, d);
    check("err_bad_op", d, exp_status());
    w1c(32'h4);
    wr(A_CTRL, ctrl_word(3'd0, 3'd5, 1'b0)); m_err = 1'b1;
    peek(A_STATUS, d);
    check("err_bad_src", d, exp_status());
    peek(A_RESULT, d);
    check("result_after_err", d, m_result);
    w1c(32'hE);

    // Unmapped address and suppressed read
    @(negedge clk);
    peek(4'd9, d);
    check("unmapped_read", d, '0);
    addr = A_RESULT; rd_en = 1'b0; #1;
    check("rd_en_low", readdata, '0);

    // CH write during RUN uses snapshot
    bus_ch(2, 32'hFFFF_0000);
    start_op(3'd3, 3'd2, 1'b0);
    bus_ch(2, 32'h0000_0001);
    finish_op();

    // Writeback beats same-cycle bus write
    bus_ch(0, 32'h1234_5678);
    start_op(3'd2, 3'd0, 1'b1);
    bus_ch(0, 32'hAAAA_5555);
    finish_op();

    // Completion beats same-cycle W1C
    w1c(32'hE);
    bus_ch(1, 32'hFFFF_FFFF);
    start_op(3'd1, 3'd1, 1'b0);
    w1c(32'hE);
    finish_op();

    // Reset mid-run
    bus_ch(2, 32'hDEAD_BEEF);
    start_op(3'd3, 3'd2, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    peek(A_STATUS, d);  check("rst_status", d, '0);
    peek(A_RESULT, d);  check("rst_result", d, '0);
    peek(A_CH0 + 4'd2, d); check("rst_ch", d, '0);
    repeat (40) @(negedge clk);
    peek(A_STATUS, d);  check("rst_no_done", d, '0);
    check("rst_irq", {31'b0, irq}, '0);
    @(negedge clk);

    // Randomized ops
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 3);
      v = (sel == 0) ? '1 : (sel == 1) ? '0 : DW'($urandom);
      bus_ch($urandom_range(0, NCH-1), v);
      ie = 1'($urandom_range(0, 1));
      wr(A_IRQ_EN, {31'b0, ie}); m_irq_en = ie;
      op  = 3'($urandom_range(0, 4));
      src = 3'($urandom_range(0, NCH-1));
      wb  = 1'($urandom_range(0, 1));
      start_op(op, src, wb);
      finish_op();
      peek(A_CTRL, d);
      check("ctrl_readback", d, m_ctrl);
      @(negedge clk);
      if (it % 3 == 2) w1c(32'hE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
